keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_CYCLES, default 16, which sets the clk cycles each column is driven before the rows are sampled.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 960000, which sets the clk cycles of each press or release debounce window.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rows, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 The block SHALL have port cols, output, 4 bits: keypad column drive, one-hot active-low.
REQ-007 The block SHALL have port key_code, output, 4 bits: code of the last accepted key, equal to row_idx*4 + col_idx.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key_code is accepted.
REQ-009 The block SHALL have port key_held, output, 1 bit: high while the accepted key is considered pressed.

Function
REQ-010 The block SHALL pass rows through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rows_s).
REQ-011 The block SHALL implement the states SCAN, DEB_PRESS, HELD and DEB_RELEASE.
REQ-012 The block SHALL hold cols = ~(1 << col_idx) at all times, with col_idx a 2-bit register.
REQ-013 In SCAN, a dwell counter SHALL count 0..SCAN_CYCLES-1; rows_s SHALL be sampled only in the cycle where dwell = SCAN_CYCLES-1.
REQ-014 In SCAN at sample time, if rows_s == 4'b1111, the block SHALL increment col_idx (3 wraps to 0), clear dwell and stay in SCAN.
REQ-015 In SCAN at sample time, if any rows_s bit is 0, the block SHALL latch row_idx as the lowest-index 0 bit, keep col_idx, clear the counter and go to DEB_PRESS.
REQ-016 In DEB_PRESS, cols SHALL stay unchanged and the counter SHALL count 0..DEBOUNCE_CYCLES-1.
REQ-017 At DEB_PRESS terminal count with rows_s[row_idx] == 0, the block SHALL update key_code, assert key_valid for exactly that next cycle, and go to HELD.
REQ-018 At DEB_PRESS terminal count with rows_s[row_idx] == 1, the block SHALL emit no pulse, advance col_idx, clear the counter and return to SCAN.
REQ-019 Bounce inside the DEB_PRESS window SHALL be ignored; only the terminal-count sample decides.
REQ-020 In HELD, key_held SHALL be 1 and other rows or keys SHALL be ignored.
REQ-021 In HELD, if rows_s[row_idx] == 1, the block SHALL clear the counter and go to DEB_RELEASE.
REQ-022 In DEB_RELEASE, key_held SHALL remain 1; if rows_s[row_idx] returns to 0 at any cycle, the block SHALL go back to HELD with no new pulse.
REQ-023 At DEB_RELEASE terminal count with the row still 1, the block SHALL deassert key_held, advance col_idx and go to SCAN.
REQ-024 key_code SHALL hold its value until the next accepted press.
REQ-025 key_valid SHALL never assert for two consecutive cycles.
REQ-026 A press held continuously SHALL produce exactly one key_valid pulse.
REQ-027 Counters SHALL be sized as $clog2 of the larger parameter and SHALL never wrap past terminal count.
REQ-028 An illegal state SHALL recover to SCAN on the next clk.

Reset
REQ-029 On reset = 0, asynchronously: state = SCAN, col_idx = 0, cols = 4'b1110, dwell and counter = 0, row_idx = 0, key_code = 0, key_valid = 0, key_held = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-debounce or during HELD SHALL abort with no key_valid pulse; after reset, scanning SHALL restart at column 0.
REQ-031 On release of reset, the first column advance SHALL occur SCAN_CYCLES cycles after the first clk edge with reset = 1.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-032 Idle scenario: rows = 1111 -> cols cycles 1110, 1101, 1011, 0111, 1110, each for 4 clk; key_valid stays 0.
REQ-033 Clean press scenario: row 2 held low while cols = 1101 -> key_code = 9, one key_valid pulse, key_held = 1; release -> key_held = 0 eight cycles later and scan resumes at 1011.
REQ-034 Glitch scenario: row 0 low for 3 cycles only -> no key_valid, return to SCAN with col_idx advanced.
REQ-035 Release-bounce scenario: in HELD, row high 3 cycles, low again, then high for 8+ cycles -> exactly one key_valid total, key_held drops only after the final window.
REQ-036 Multi-key scenario: rows 1 and 3 both low on column 0 -> key_code = 4; pressing another key while in HELD -> no additional pulse.
REQ-037 Reset scenario: reset pulsed low mid-DEB_PRESS -> outputs immediately at reset values and no key_valid afterward.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sampling, press/release debounce.
// Emits a one-cycle key_valid per accepted press and key_held while down.
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ?
                          SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [1:0]      r_col;
    logic [1:0]      w_col_nx;
    logic [1:0]      r_row;
    logic [1:0]      w_row_nx;
    logic [1:0]      w_row_low;
    logic [3:0]      r_code;
    logic [3:0]      w_code_nx;
    logic            r_valid;
    logic            w_valid_nx;
    logic            w_row_s;

    // Two-flop synchronizer for the asynchronous row lines (idle high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
        end
    end

    assign w_row_s = r_sync2[r_row];

    // Lowest-index active (low) row wins when several rows are down
    always_comb begin
        w_row_low = 2'd3;
        if (!r_sync2[0])      w_row_low = 2'd0;
        else if (!r_sync2[1]) w_row_low = 2'd1;
        else if (!r_sync2[2]) w_row_low = 2'd2;
    end

    // Next-state and datapath decisions for the scan/debounce FSM
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_cnt == SCAN_TC) begin
                    w_cnt_nx = '0;
                    if (&r_sync2) begin
                        w_col_nx = r_col + 2'd1;
                    end else begin
                        w_row_nx   = w_row_low;
                        w_state_nx = DEB_PRESS;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (r_cnt == DEB_TC) begin
                    w_cnt_nx = '0;
                    if (!w_row_s) begin
                        w_code_nx  = {r_row, r_col};
                        w_valid_nx = 1'b1;
                        w_state_nx = HELD;
                    end else begin
                        w_col_nx   = r_col + 2'd1;
                        w_state_nx = SCAN;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (w_row_s) begin
                    w_cnt_nx   = '0;
                    w_state_nx = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (!w_row_s) begin
                    w_cnt_nx   = '0;
                    w_state_nx = HELD;
                end else if (r_cnt == DEB_TC) begin
                    w_cnt_nx   = '0;
                    w_col_nx   = r_col + 2'd1;
                    w_state_nx = SCAN;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = SCAN;
            end
        endcase
    end

    // State, counter, column/row indices and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = (r_state == HELD) || (r_state == DEB_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: passive 4x4 keypad model plus a
// scoreboard of expected key codes popped on every key_valid pulse.
module tb_keypad_scan_ctrl;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;
    logic [3:0]  exp_q[$];
    logic        prev_valid;
    int          n_tests;
    int          n_fail;
    int          n_pulses;

    keypad_scan_ctrl #(
        .SCAN_CYCLES(SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column when driven low
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each pulse must match the oldest expected code
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            n_pulses++;
            check("valid_back_to_back", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0)
                check("unexpected_pulse", 32'd1, 32'd0);
            else
                check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
        end
        prev_valid = key_valid;
    end

    task automatic wait_cols(input logic [3:0] tgt, input string tag);
        int n = 0;
        while (cols !== tgt && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(cols), 32'(tgt));
    endtask

    task automatic wait_pulse(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic held_time(output int n);
        n = 0;
        @(negedge clk);
        while (key_held === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] seq [4];
        seq[0] = 4'b1110;
        seq[1] = 4'b1101;
        seq[2] = 4'b1011;
        seq[3] = 4'b0111;
        n_tests  = 0;
        n_fail   = 0;
        n_pulses = 0;
        pressed  = 16'h0;
        reset    = 1'b0;

        #3;
        check("rst_cols", 32'(cols), 32'h e);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle scan: each column for SCAN clocks, wrapping back to col 0
        for (int e = 1; e < 20; e++) begin
            @(negedge clk);
            check("idle_cols", 32'(cols), 32'(seq[(e / SCAN) % 4]));
        end

        // Glitch: row 0 low for 3 clocks on col 0, caught by the sample
        wait_cols(4'b0111, "sync_col3");
        wait_cols(4'b1110, "sync_col0");
        pressed[0] = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            if (k == 3) pressed[0] = 1'b0;
            if (cols !== 4'b1110) break;
            n++;
            @(negedge clk);
        end
        check("glitch_col0_len", 32'(n), 32'(SCAN + DEB));
        check("glitch_next_col", 32'(cols), 32'h d);

        // Clean press on row 2 / col 1 -> code 9, then clean release
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_pulse("press9_pulse");
        check("press9_held", 32'(key_held), 32'd1);
        @(negedge clk);
        check("press9_one_cycle", 32'(key_valid), 32'd0);
        repeat (3) @(negedge clk);
        pressed[9] = 1'b0;
        held_time(n);
        check("release_time", 32'(n), 32'(DEB + 2));
        check("resume_col2", 32'(cols), 32'h b);

        // Release bounce: short release is absorbed, no new pulse
        pressed[9] = 1'b1;
        exp_q.push_back(4'd9);
        wait_pulse("bounce_pulse");
        repeat (3) @(negedge clk);
        pressed[9] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bounce_up_held", 32'(key_held), 32'd1);
        end
        pressed[9] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("bounce_down_held", 32'(key_held), 32'd1);
        end
        pressed[9] = 1'b0;
        held_time(n);
        check("bounce_release_time", 32'(n), 32'(DEB + 2));

        // Multi-key on col 0: rows 1 and 3 -> lowest row wins (code 4)
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        exp_q.push_back(4'd4);
        wait_pulse("multi_pulse");
        pressed[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("multi_held", 32'(key_held), 32'd1);
        end
        pressed = 16'h0;
        held_time(n);
        check("multi_release_time", 32'(n), 32'(DEB + 2));

        // Reset in the middle of a press debounce window
        wait_cols(4'b0111, "rst_sync_col3");
        wait_cols(4'b1110, "rst_sync_col0");
        pressed[0] = 1'b1;
        repeat (7) @(negedge clk);
        check("code_retained", 32'(key_code), 32'd4);
        reset = 1'b0;
        #1;
        check("mid_rst_cols", 32'(cols), 32'h e);
        check("mid_rst_code", 32'(key_code), 32'd0);
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_held", 32'(key_held), 32'd0);
        pressed[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cols === 4'b1110 && n < 50);
        check("first_advance_edges", 32'(n), 32'(SCAN));
        check("first_advance_col", 32'(cols), 32'h d);
        repeat (30) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_pulses", 32'(n_pulses), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
